// File: rtl/edge_evt_pkg.sv
// Shared types and constants for the edge event arbiter.
package edge_evt_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  localparam int N_CH_DEFAULT = 4;
  localparam int ARM_DLY      = 3;

endpackage

// File: rtl/sig_sync_edge.sv
// One channel: 2-flop synchronizer, previous-value flop and qualified rising-edge pulse.
module sig_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  input  logic en,
  input  logic armed,
  output logic rise
);

  logic s1;
  logic s2;
  logic prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      prev <= 1'b0;
    end else begin
      s1   <= sig;
      s2   <= s1;
      prev <= s2;
    end
  end

  assign rise = s2 & ~prev & en & armed;

endmodule

// File: rtl/edge_event_arbiter.sv
// Latches rising edges from N_CH asynchronous inputs and presents them one at a
// time to a valid/ready consumer in round-robin order, flagging lost events.
//
//   state   | meaning
//   IDLE    | nothing presented, evt_valid=0
//   PRESENT | evt_ch presented, evt_valid=1, waiting for evt_ready
module edge_event_arbiter
  import edge_evt_pkg::*;
#(
  parameter int N_CH = N_CH_DEFAULT,
  parameter int CW   = $clog2(N_CH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] sig,
  input  logic [N_CH-1:0] en,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic [CW-1:0]   evt_ch,
  output logic [N_CH-1:0] pending,
  output logic [N_CH-1:0] overrun,
  input  logic [N_CH-1:0] ovr_clr
);

  localparam int AW = $clog2(ARM_DLY + 1);

  state_t          state;
  logic [CW-1:0]   last;
  logic [AW-1:0]   arm_cnt;
  logic            armed;
  logic [N_CH-1:0] rise;
  logic            do_grant;
  logic [CW-1:0]   gnt_idx;
  logic [CW-1:0]   hi_idx;
  logic [CW-1:0]   lo_idx;
  logic            hi_found;
  logic [N_CH-1:0] gnt_onehot;
  logic [N_CH-1:0] pending_n;
  logic [N_CH-1:0] overrun_n;

  // Edges are ignored until the synchronizers and prev flops have settled after reset.
  assign armed = (arm_cnt == AW'(ARM_DLY));

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    sig_sync_edge u_sync (
      .clk   (clk),
      .rst   (rst),
      .sig   (sig[g]),
      .en    (en[g]),
      .armed (armed),
      .rise  (rise[g])
    );
  end

  // Round-robin: lowest pending index above last, else lowest pending overall.
  always_comb begin
    hi_idx   = '0;
    lo_idx   = '0;
    hi_found = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (pending[i]) begin
        lo_idx = CW'(i);
        if (CW'(i) > last) begin
          hi_idx   = CW'(i);
          hi_found = 1'b1;
        end
      end
    end
    gnt_idx  = hi_found ? hi_idx : lo_idx;
    do_grant = (|pending) && ((state == IDLE) || evt_ready);

    gnt_onehot = '0;
    if (do_grant) gnt_onehot[gnt_idx] = 1'b1;

    // A new edge on the channel being granted re-arms it without loss.
    pending_n = (pending & ~gnt_onehot) | rise;
    overrun_n = (overrun & ~ovr_clr) | (rise & pending & ~gnt_onehot);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      evt_valid <= 1'b0;
      evt_ch    <= '0;
      last      <= CW'(N_CH - 1);
      pending   <= '0;
      overrun   <= '0;
      arm_cnt   <= '0;
    end else begin
      pending <= pending_n;
      overrun <= overrun_n;
      if (!armed) arm_cnt <= arm_cnt + AW'(1);

      case (state)
        IDLE: begin
          if (do_grant) begin
            state     <= PRESENT;
            evt_valid <= 1'b1;
            evt_ch    <= gnt_idx;
            last      <= gnt_idx;
          end
        end
        PRESENT: begin
          if (evt_ready) begin
            if (do_grant) begin
              evt_ch <= gnt_idx;
              last   <= gnt_idx;
            end else begin
              state     <= IDLE;
              evt_valid <= 1'b0;
            end
          end
        end
        default: begin
          state     <= IDLE;
          evt_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed bench for edge_event_arbiter with hand-computed expectations.
module tb_edge_event_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] sig;
  logic [3:0] en;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_ch;
  logic [3:0] pending;
  logic [3:0] overrun;
  logic [3:0] ovr_clr;

  int n_chk;
  int n_fail;

  edge_event_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .sig       (sig),
    .en        (en),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_ch    (evt_ch),
    .pending   (pending),
    .overrun   (overrun),
    .ovr_clr   (ovr_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    repeat (5) tick();
  endtask

  // Two cycles high, two low: one edge, latched two edges after the rise.
  task automatic pulse(input int ch);
    sig[ch] = 1'b1;
    tick();
    tick();
    sig[ch] = 1'b0;
    tick();
    tick();
  endtask

  task automatic burst_all(input string tag, input int c0, input int c1, input int c2, input int c3);
    int seq [4];
    seq[0] = c0; seq[1] = c1; seq[2] = c2; seq[3] = c3;
    sig = 4'hF;
    tick();
    tick();
    tick();
    chk({tag, "_pend"}, 32'(pending), 32'hF);
    chk({tag, "_idle"}, 32'(evt_valid), 32'd0);
    sig = 4'h0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("%s_v%0d", tag, i), 32'(evt_valid), 32'd1);
      chk($sformatf("%s_ch%0d", tag, i), 32'(evt_ch), 32'(seq[i]));
    end
    tick();
    chk({tag, "_end"}, 32'(evt_valid), 32'd0);
    tick();
    tick();
  endtask

  initial begin
    int seen;
    int cnt;
    int ch_seen;
    n_chk     = 0;
    n_fail    = 0;
    sig       = '0;
    en        = 4'hF;
    evt_ready = 1'b0;
    ovr_clr   = '0;

    rst = 1'b1;
    tick();
    tick();
    chk("rst_valid", 32'(evt_valid), 32'd0);
    chk("rst_ch", 32'(evt_ch), 32'd0);
    chk("rst_pend", 32'(pending), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    rst = 1'b0;
    repeat (5) tick();

    // single event on channel 2: latency and one-cycle presentation
    evt_ready = 1'b1;
    sig[2] = 1'b1;
    tick();
    tick();
    chk("lat_pend_k1", 32'(pending), 32'h0);
    tick();
    chk("lat_pend_k2", 32'(pending), 32'h4);
    chk("lat_valid_k2", 32'(evt_valid), 32'd0);
    tick();
    chk("lat_valid_k3", 32'(evt_valid), 32'd1);
    chk("lat_ch_k3", 32'(evt_ch), 32'd2);
    chk("lat_pend_k3", 32'(pending), 32'h0);
    sig[2] = 1'b0;
    tick();
    chk("lat_valid_k4", 32'(evt_valid), 32'd0);
    tick();
    tick();

    // round-robin continues after last grant 2, then from a fresh reset
    burst_all("rr_after2", 3, 0, 1, 2);
    do_reset();
    burst_all("rr_reset", 0, 1, 2, 3);

    // overrun while another channel is held, set beats clear
    evt_ready = 1'b0;
    pulse(0);
    chk("ovr_present_v", 32'(evt_valid), 32'd1);
    chk("ovr_present_ch", 32'(evt_ch), 32'd0);
    pulse(1);
    chk("ovr_first_pend", 32'(pending), 32'h2);
    chk("ovr_first_ovr", 32'(overrun), 32'h0);
    pulse(1);
    chk("ovr_second_ovr", 32'(overrun), 32'h2);
    chk("ovr_hold_ch", 32'(evt_ch), 32'd0);
    pulse(2);
    sig[2] = 1'b1;
    tick();
    tick();
    ovr_clr = 4'b0100;
    tick();
    ovr_clr = 4'b0000;
    sig[2] = 1'b0;
    tick();
    tick();
    chk("set_wins_ovr", 32'(overrun), 32'h6);
    evt_ready = 1'b1;
    tick();
    chk("ovr_hs1_ch", 32'(evt_ch), 32'd1);
    tick();
    chk("ovr_hs2_ch", 32'(evt_ch), 32'd2);
    tick();
    chk("ovr_hs_idle", 32'(evt_valid), 32'd0);
    chk("ovr_sticky", 32'(overrun), 32'h6);
    evt_ready = 1'b0;
    ovr_clr = 4'b0010;
    tick();
    ovr_clr = 4'b0000;
    chk("ovr_clr1", 32'(overrun), 32'h4);
    ovr_clr = 4'b0100;
    tick();
    ovr_clr = 4'b0000;
    chk("ovr_clr2", 32'(overrun), 32'h0);

    // second edge on the presented channel: no overrun, presented again
    pulse(1);
    chk("reedge_ch", 32'(evt_ch), 32'd1);
    pulse(1);
    chk("reedge_pend", 32'(pending), 32'h2);
    chk("reedge_ovr", 32'(overrun), 32'h0);
    evt_ready = 1'b1;
    tick();
    chk("reedge_again_v", 32'(evt_valid), 32'd1);
    chk("reedge_again_ch", 32'(evt_ch), 32'd1);
    tick();
    chk("reedge_idle", 32'(evt_valid), 32'd0);
    chk("reedge_ovr2", 32'(overrun), 32'h0);

    // edge on a channel in the same cycle it is granted
    evt_ready = 1'b0;
    pulse(0);
    pulse(1);
    chk("samecyc_pre_pend", 32'(pending), 32'h2);
    sig[1] = 1'b1;
    tick();
    tick();
    evt_ready = 1'b1;
    tick();
    sig[1] = 1'b0;
    chk("samecyc_ch", 32'(evt_ch), 32'd1);
    chk("samecyc_pend", 32'(pending), 32'h2);
    chk("samecyc_ovr", 32'(overrun), 32'h0);
    tick();
    chk("samecyc_again_v", 32'(evt_valid), 32'd1);
    chk("samecyc_again_ch", 32'(evt_ch), 32'd1);
    tick();
    chk("samecyc_idle", 32'(evt_valid), 32'd0);

    // disabling a channel masks new edges but keeps the latched one
    evt_ready = 1'b0;
    pulse(0);
    pulse(2);
    en = 4'b1011;
    pulse(2);
    chk("en_mask_ovr", 32'(overrun), 32'h0);
    chk("en_keep_pend", 32'(pending), 32'h4);
    evt_ready = 1'b1;
    tick();
    chk("en_keep_ch", 32'(evt_ch), 32'd2);
    tick();
    chk("en_keep_idle", 32'(evt_valid), 32'd0);
    pulse(2);
    chk("en_mask_pend", 32'(pending), 32'h0);
    chk("en_mask_valid", 32'(evt_valid), 32'd0);
    en = 4'hF;

    // level held high across reset release produces no event
    sig[3] = 1'b1;
    do_reset();
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (evt_valid || (pending != 4'h0)) seen++;
      tick();
    end
    chk("arm_no_event", 32'(seen), 32'd0);
    sig[3] = 1'b0;
    tick();
    tick();
    sig[3] = 1'b1;
    cnt = 0;
    ch_seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (evt_valid) begin
        cnt++;
        ch_seen = int'(evt_ch);
      end
    end
    chk("arm_one_event", 32'(cnt), 32'd1);
    chk("arm_event_ch", 32'(ch_seen), 32'd3);
    sig[3] = 1'b0;
    repeat (3) tick();

    // reset while presenting discards the event
    evt_ready = 1'b0;
    pulse(0);
    pulse(1);
    chk("rstp_pre_v", 32'(evt_valid), 32'd1);
    rst = 1'b1;
    tick();
    chk("rstp_valid", 32'(evt_valid), 32'd0);
    chk("rstp_pend", 32'(pending), 32'h0);
    chk("rstp_ch", 32'(evt_ch), 32'd0);
    rst = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
